// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types and constants for the bus arbiter
package bus_arb_pkg;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam int NREQ_DEF  = 4;
   localparam int WIDTH_DEF = 16;
   localparam int PTR_W_DEF = $clog2(NREQ_DEF);

   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/buf_and.sv
// rtl/buf_and.sv - bus buffer AND gate: passes the word only while enabled
module buf_and #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic             en,
   output logic [WIDTH-1:0] y
);

   assign y = a & {WIDTH{en}};

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting after the last winner
module rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   last,
   output logic [NREQ-1:0] gnt,
   output logic [PW-1:0]   idx,
   output logic            any_req
);

   always_comb begin
      logic [PW-1:0] cand;
      gnt     = '0;
      idx     = '0;
      any_req = 1'b0;
      cand    = '0;
      // scan last+1 .. last+NREQ so the previous winner is visited last
      for (int k = 1; k <= NREQ; k++) begin
         cand = PW'((int'(last) + k) % NREQ);
         if (!any_req && req[cand]) begin
            any_req   = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin owner of the internal data bus with valid/ready output
// Optional burst lock is compiled in with BUS_ARB_LOCK_EN.
module bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int NREQ     = NREQ_DEF,
   parameter int WIDTH    = WIDTH_DEF,
   parameter int LOCK_MAX = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_data,
`ifdef BUS_ARB_LOCK_EN
   input  logic [NREQ-1:0]       req_lock,
`endif
   output logic [NREQ-1:0]       grant,
   output logic [NREQ-1:0]       ack,
   output logic [WIDTH-1:0]      bus_data,
   output logic                  bus_valid,
   input  logic                  bus_ready
);

   localparam int   PW     = ptr_w(NREQ);
   localparam logic S_IDLE = IDLE;
   localparam logic S_BUSY = BUSY;

   logic             state;
   logic [PW-1:0]    last;
   logic             xfer;
   logic             hold;
   logic [NREQ-1:0]  pick_gnt;
   logic [PW-1:0]    pick_idx;
   logic             pick_any;
   logic [WIDTH-1:0] gated [NREQ];

   assign xfer = bus_valid & bus_ready;
   assign ack  = grant & {NREQ{bus_ready}};

   // the source being acked this edge drops to lowest priority
   rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req     (req & ~ack),
      .last    (last),
      .gnt     (pick_gnt),
      .idx     (pick_idx),
      .any_req (pick_any)
   );

`ifdef BUS_ARB_LOCK_EN
   localparam int LW = $clog2(LOCK_MAX + 1);
   logic [LW-1:0] lock_cnt;

   assign hold = req_lock[last] && (lock_cnt != LW'(LOCK_MAX - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_cnt <= '0;
      end else if (state == S_BUSY && xfer && hold) begin
         lock_cnt <= lock_cnt + 1'b1;
      end else if (state == S_IDLE || xfer) begin
         lock_cnt <= '0;
      end
   end
`else
   logic unused_lock_max;
   assign hold            = 1'b0;
   assign unused_lock_max = (LOCK_MAX > 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         last      <= PW'(NREQ - 1);
         grant     <= '0;
         bus_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pick_any) begin
                  grant     <= pick_gnt;
                  last      <= pick_idx;
                  bus_valid <= 1'b1;
                  state     <= S_BUSY;
               end
            end
            default: begin
               if (xfer && !hold) begin
                  if (pick_any) begin
                     grant <= pick_gnt;
                     last  <= pick_idx;
                  end else begin
                     grant     <= '0;
                     bus_valid <= 1'b0;
                     state     <= S_IDLE;
                  end
               end
            end
         endcase
      end
   end

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_src
      buf_and #(.WIDTH(WIDTH)) u_gate (
         .a  (req_data[gi*WIDTH +: WIDTH]),
         .en (grant[gi]),
         .y  (gated[gi])
      );
   end

   always_comb begin
      bus_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         bus_data = bus_data | gated[i];
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed scoreboard bench for bus_arbiter
module tb_bus_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 16;
`ifdef BUS_ARB_LOCK_EN
   localparam int LOCK_MAX = 3;
`else
   localparam int LOCK_MAX = 8;
`endif

   typedef struct {
      logic [NREQ-1:0]  g;
      logic [WIDTH-1:0] d;
   } xfer_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       ack;
   logic [WIDTH-1:0]      bus_data;
   logic                  bus_valid;
   logic                  bus_ready;
`ifdef BUS_ARB_LOCK_EN
   logic [NREQ-1:0]       req_lock;
`endif

   int    cnt    [NREQ];
   int    seq    [NREQ];
   int    pushed [NREQ];
   bit    lock_en[NREQ];
   xfer_t exp_q[$];
   int    tests  = 0;
   int    fails  = 0;
   bit    chk_en = 1'b0;

   bus_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LOCK_MAX(LOCK_MAX)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_data  (req_data),
`ifdef BUS_ARB_LOCK_EN
      .req_lock  (req_lock),
`endif
      .grant     (grant),
      .ack       (ack),
      .bus_data  (bus_data),
      .bus_valid (bus_valid),
      .bus_ready (bus_ready)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         tests++;
         assert ((grant & ~req) === '0)
         else begin
            fails++;
            $error("FAIL protocol observed grant=%b req=%b", grant, req);
         end
      end
   end

   function automatic logic [WIDTH-1:0] word_data(input int i, input int n);
      return 16'hA5A5 ^ {8'(i), 8'(n)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      for (int i = 0; i < NREQ; i++) begin
         req[i] = (cnt[i] != 0);
         req_data[i*WIDTH +: WIDTH] = word_data(i, seq[i]);
`ifdef BUS_ARB_LOCK_EN
         req_lock[i] = lock_en[i] && (cnt[i] > 1);
`endif
      end
   endtask

   task automatic expect_xfer(input int i);
      xfer_t x;
      x.g = NREQ'(1) << i;
      x.d = word_data(i, pushed[i]);
      pushed[i]++;
      exp_q.push_back(x);
   endtask

   // one clock: compare any transfer in this cycle, then let acked sources advance
   task automatic tick();
      logic [NREQ-1:0] acked;
      xfer_t x;
      #1;
      acked = '0;
      if (bus_valid && bus_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected", 32'(grant), 32'd0);
         end else begin
            x = exp_q.pop_front();
            check("sb_grant", 32'(grant), 32'(x.g));
            check("sb_data", 32'(bus_data), 32'(x.d));
            check("sb_ack", 32'(ack), 32'(x.g));
         end
         acked = grant;
      end else begin
         check("no_ack", 32'(ack), 32'd0);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (acked[i]) begin
            cnt[i]--;
            seq[i]++;
         end
      end
      refresh();
   endtask

   initial begin
      logic [WIDTH-1:0] held;
      rst       = 1'b1;
      bus_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         cnt[i] = 0; seq[i] = 0; pushed[i] = 0; lock_en[i] = 1'b0;
      end
      refresh();
      repeat (2) @(posedge clk);
      #1;
      bus_ready = 1'b1;
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_valid", 32'(bus_valid), 32'd0);
      check("rst_data", 32'(bus_data), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      rst    = 1'b0;
      chk_en = 1'b1;

      // single word from source 0
      cnt[0] = 1; refresh(); expect_xfer(0);
      tick();
      check("t1_latency_valid", 32'(bus_valid), 32'd1);
      check("t1_latency_data", 32'(bus_data), 32'hA5A5);
      tick();
      check("t1_idle_grant", 32'(grant), 32'd0);
      check("t1_idle_valid", 32'(bus_valid), 32'd0);

      // consumer stall, sources 1 and 2
      bus_ready = 1'b0;
      cnt[1] = 1; cnt[2] = 1; refresh(); expect_xfer(1); expect_xfer(2);
      tick();
      check("stall_grant", 32'(grant), 32'b0010);
      held = bus_data;
      check("stall_data", 32'(held), 32'(word_data(1, 0)));
      for (int c = 0; c < 3; c++) begin
         tick();
         check("stall_hold_grant", 32'(grant), 32'b0010);
         check("stall_hold_data", 32'(bus_data), 32'(held));
      end
      bus_ready = 1'b1;
      tick();
      check("stall_next_grant", 32'(grant), 32'b0100);
      tick();
      check("stall_end_grant", 32'(grant), 32'd0);

      // all four requesting, last winner was source 2
      for (int i = 0; i < NREQ; i++) cnt[i] = 1;
      refresh();
      expect_xfer(3); expect_xfer(0); expect_xfer(1); expect_xfer(2);
      tick();
      for (int k = 0; k < 4; k++) begin
         check("rot_a_valid", 32'(bus_valid), 32'd1);
         tick();
      end
      check("rot_a_end_grant", 32'(grant), 32'd0);

      // reset while source 2 is stalled on the bus
      bus_ready = 1'b0;
      cnt[2] = 1; refresh();
      tick();
      check("mid_rst_grant_before", 32'(grant), 32'b0100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus_ready = 1'b1;
      check("mid_rst_grant", 32'(grant), 32'd0);
      check("mid_rst_valid", 32'(bus_valid), 32'd0);
      check("mid_rst_data", 32'(bus_data), 32'd0);
      check("mid_rst_ack", 32'(ack), 32'd0);
      cnt[0] = 2; cnt[1] = 1; cnt[3] = 1; refresh();
      expect_xfer(0); expect_xfer(1); expect_xfer(2); expect_xfer(3); expect_xfer(0);
      tick();
      check("rot_b_first", 32'(grant), 32'b0001);
      for (int k = 0; k < 5; k++) begin
         check("rot_b_valid", 32'(bus_valid), 32'd1);
         tick();
      end
      check("rot_b_end_grant", 32'(grant), 32'd0);

      // source 0 asks for a locked burst against source 1
      rst = 1'b1;
      tick();
      rst = 1'b0;
      lock_en[0] = 1'b1;
      cnt[0] = 4; cnt[1] = 2; refresh();
`ifdef BUS_ARB_LOCK_EN
      expect_xfer(0); expect_xfer(0); expect_xfer(0);
      expect_xfer(1); expect_xfer(0); expect_xfer(1);
`else
      expect_xfer(0); expect_xfer(1); expect_xfer(0);
      expect_xfer(1); expect_xfer(0); expect_xfer(0);
`endif
      for (int k = 0; k < 10; k++) tick();
      check("lock_end_grant", 32'(grant), 32'd0);

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
